// File: rtl/hazard_pkg.sv
// hazard_pkg: shared state encoding and constants for the pipeline hazard controller
package hazard_pkg;
  typedef enum logic [1:0] {RUN, MEM_WAIT, ERR} state_e;
  localparam logic [4:0] REG_ZERO = 5'd0;
  localparam int PERF_W = 32;
endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// pipeline_hazard_ctrl_if: decoded pipeline control bits in, stage enables/flushes and status out
interface pipeline_hazard_ctrl_if;
  import hazard_pkg::*;
  logic [4:0] id_rs1, id_rs2, ex_rd;
  logic ex_memread, ex_redirect, mem_req, mem_ready;
  logic pc_write, if_id_write, if_id_flush, id_ex_write, id_ex_flush;
  logic ex_mem_write, mem_wb_write, mem_err;
  logic [PERF_W-1:0] stall_cycles, redirect_count;
  modport master (
    output id_rs1, id_rs2, ex_rd, ex_memread, ex_redirect, mem_req, mem_ready,
    input  pc_write, if_id_write, if_id_flush, id_ex_write, id_ex_flush,
           ex_mem_write, mem_wb_write, mem_err, stall_cycles, redirect_count
  );
  modport slave (
    input  id_rs1, id_rs2, ex_rd, ex_memread, ex_redirect, mem_req, mem_ready,
    output pc_write, if_id_write, if_id_flush, id_ex_write, id_ex_flush,
           ex_mem_write, mem_wb_write, mem_err, stall_cycles, redirect_count
  );
endinterface

// File: rtl/hazard_wait_timer.sv
// hazard_wait_timer: saturating count of consecutive memory-wait cycles, flags the last allowed one
module hazard_wait_timer #(
  parameter int WAIT_TIMEOUT = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic expire
);
  logic [15:0] cnt_q, cnt_d;
  // clear wins over count; the count sticks at all-ones instead of wrapping
  always_comb cnt_d = clr ? '0 : (en && cnt_q != '1) ? cnt_q + 16'd1 : cnt_q;
  // timer register
  always_ff @(posedge clk or posedge reset)
    if (reset) cnt_q <= '0;
    else cnt_q <= cnt_d;
  assign expire = cnt_q == 16'(WAIT_TIMEOUT - 1);
endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: stall/flush sequencing for the 5-stage core; HAZARD_PERF_EN adds perf counters
module pipeline_hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int WAIT_TIMEOUT = 16
) (
  input logic clk,
  input logic reset,
  pipeline_hazard_ctrl_if.slave bus
);
  state_e state_q, state_d;
  logic freeze, redirect, load_use, expire;
  hazard_wait_timer #(.WAIT_TIMEOUT(WAIT_TIMEOUT)) u_timer (
    .clk(clk), .reset(reset), .clr(state_q != MEM_WAIT), .en(state_q == MEM_WAIT), .expire(expire)
  );
  // priority: freeze over redirect over load-use; a held redirect simply waits out the freeze
  always_comb begin
    freeze = state_q == ERR || (bus.mem_req && !bus.mem_ready);
    redirect = !freeze && bus.ex_redirect;
    load_use = !freeze && !redirect && bus.ex_memread && bus.ex_rd != REG_ZERO &&
               (bus.ex_rd == bus.id_rs1 || bus.ex_rd == bus.id_rs2);
    state_d = state_q == ERR ? ERR :
              state_q == MEM_WAIT ? (bus.mem_ready ? RUN : expire ? ERR : MEM_WAIT) :
              (bus.mem_req && !bus.mem_ready) ? MEM_WAIT : RUN;
  end
  // state register; ERR only leaves through reset
  always_ff @(posedge clk or posedge reset)
    if (reset) state_q <= RUN;
    else state_q <= state_d;
  assign bus.pc_write     = !freeze && !load_use;
  assign bus.if_id_write  = !freeze && !load_use;
  assign bus.id_ex_write  = !freeze;
  assign bus.ex_mem_write = !freeze;
  assign bus.mem_wb_write = !freeze;
  assign bus.if_id_flush  = redirect;
  assign bus.id_ex_flush  = redirect || load_use;
  assign bus.mem_err      = state_q == ERR;
`ifdef HAZARD_PERF_EN
  logic [PERF_W-1:0] stall_q, stall_d, redir_q, redir_d;
  // wrapping event counters
  always_comb begin
    stall_d = bus.pc_write ? stall_q : stall_q + 1'b1;
    redir_d = redirect ? redir_q + 1'b1 : redir_q;
  end
  // counter registers
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      stall_q <= '0;
      redir_q <= '0;
    end else begin
      stall_q <= stall_d;
      redir_q <= redir_d;
    end
  assign bus.stall_cycles   = stall_q;
  assign bus.redirect_count = redir_q;
`else
  assign bus.stall_cycles   = '0;
  assign bus.redirect_count = '0;
`endif
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb_pipeline_hazard_ctrl: directed vectors plus multi-cycle stall/timeout sequences
module tb_pipeline_hazard_ctrl;
  import hazard_pkg::*;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int tests = 0;
  int fails = 0;
`ifdef HAZARD_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif
  // {pc_write, if_id_write, if_id_flush, id_ex_write, id_ex_flush, ex_mem_write, mem_wb_write}
  localparam logic [6:0] NORM = 7'b1101011;
  localparam logic [6:0] LU   = 7'b0001111;
  localparam logic [6:0] RDR  = 7'b1111111;
  localparam logic [6:0] FRZ  = 7'b0000000;
  typedef struct {
    string name;
    logic [4:0] rs1, rs2, rd;
    logic memread, redirect, req, ready;
    logic [6:0] exp;
  } vec_t;
  vec_t vecs[10];
  pipeline_hazard_ctrl_if bus();
  pipeline_hazard_ctrl #(.WAIT_TIMEOUT(4)) dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  function automatic logic [6:0] outs();
    return {bus.pc_write, bus.if_id_write, bus.if_id_flush, bus.id_ex_write,
            bus.id_ex_flush, bus.ex_mem_write, bus.mem_wb_write};
  endfunction
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask
  task automatic drive(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                       input logic memread, input logic redirect, input logic req, input logic ready);
    bus.id_rs1 = rs1;
    bus.id_rs2 = rs2;
    bus.ex_rd = rd;
    bus.ex_memread = memread;
    bus.ex_redirect = redirect;
    bus.mem_req = req;
    bus.mem_ready = ready;
  endtask
  task automatic step(input logic redirect, input logic req, input logic ready);
    @(negedge clk);
    drive(5'd1, 5'd2, 5'd3, 1'b0, redirect, req, ready);
    #1;
  endtask
  task automatic do_reset();
    @(negedge clk);
    drive(5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 1'b0, 1'b0);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask
  initial begin
    vecs[0] = '{"normal",          5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 1'b0, 1'b0, NORM};
    vecs[1] = '{"lu_rs2",          5'd1, 5'd5, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, LU};
    vecs[2] = '{"lu_rs1",          5'd9, 5'd2, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0, LU};
    vecs[3] = '{"lu_rd_zero",      5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, NORM};
    vecs[4] = '{"no_load",         5'd5, 5'd5, 5'd5, 1'b0, 1'b0, 1'b0, 1'b0, NORM};
    vecs[5] = '{"lu_no_match",     5'd4, 5'd6, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, NORM};
    vecs[6] = '{"redirect",        5'd1, 5'd2, 5'd3, 1'b0, 1'b1, 1'b0, 1'b0, RDR};
    vecs[7] = '{"redirect_and_lu", 5'd5, 5'd5, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0, RDR};
    vecs[8] = '{"mem_ready_hit",   5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 1'b1, 1'b1, NORM};
    vecs[9] = '{"lu_with_mem_hit", 5'd7, 5'd2, 5'd7, 1'b1, 1'b0, 1'b1, 1'b1, LU};
    drive(5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 1'b0, 1'b0);
    #2;
    chk("reset_outs", 32'(outs()), 32'(NORM));
    chk("reset_err", 32'(bus.mem_err), 32'd0);
    chk("reset_stall_cnt", bus.stall_cycles, 32'd0);
    chk("reset_redir_cnt", bus.redirect_count, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      drive(vecs[i].rs1, vecs[i].rs2, vecs[i].rd, vecs[i].memread, vecs[i].redirect, vecs[i].req, vecs[i].ready);
      #1;
      chk(vecs[i].name, 32'(outs()), 32'(vecs[i].exp));
    end
    do_reset();
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b1, 1'b0);
      chk("memwait_frozen", 32'(outs()), 32'(FRZ));
    end
    step(1'b0, 1'b1, 1'b1);
    chk("memwait_release", 32'(outs()), 32'(NORM));
    step(1'b0, 1'b0, 1'b0);
    chk("memwait_after", 32'(outs()), 32'(NORM));
    chk("memwait_stall_cnt", bus.stall_cycles, PERF ? 32'd3 : 32'd0);
    chk("memwait_err", 32'(bus.mem_err), 32'd0);
    do_reset();
    for (int i = 0; i < 2; i++) begin
      step(1'b1, 1'b1, 1'b0);
      chk("redir_frozen", 32'(outs()), 32'(FRZ));
    end
    step(1'b1, 1'b1, 1'b1);
    chk("redir_release", 32'(outs()), 32'(RDR));
    step(1'b0, 1'b0, 1'b0);
    chk("redir_after", 32'(outs()), 32'(NORM));
    chk("redir_count", bus.redirect_count, PERF ? 32'd1 : 32'd0);
    chk("redir_stall_cnt", bus.stall_cycles, PERF ? 32'd2 : 32'd0);
    do_reset();
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 1'b1, 1'b0);
      chk("timeout_pre_err", 32'(bus.mem_err), 32'd0);
      chk("timeout_pre_outs", 32'(outs()), 32'(FRZ));
    end
    step(1'b0, 1'b1, 1'b0);
    chk("timeout_err", 32'(bus.mem_err), 32'd1);
    for (int i = 0; i < 2; i++) begin
      step(1'b0, 1'b0, 1'b1);
      chk("err_sticky", 32'(bus.mem_err), 32'd1);
      chk("err_frozen", 32'(outs()), 32'(FRZ));
    end
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("async_rst_err", 32'(bus.mem_err), 32'd0);
    chk("async_rst_outs", 32'(outs()), 32'(NORM));
    chk("async_rst_stall", bus.stall_cycles, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    drive(5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 1'b0, 1'b0);
    #1;
    chk("rst_memwait_outs", 32'(outs()), 32'(NORM));
    chk("rst_memwait_stall", bus.stall_cycles, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 1'b1, 1'b0);
      chk("rst_timer_cleared", 32'(bus.mem_err), 32'd0);
    end
    step(1'b0, 1'b1, 1'b0);
    chk("rst_timeout_again", 32'(bus.mem_err), 32'd1);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/pipeline_hazard_ctrl.md
# pipeline_hazard_ctrl

Pipeline sequencing controller for the 5-stage RISC-V core. Generates PC and pipeline-register write enables and flushes from decoded control bits of the ID, EX and MEM stages. Handles load-use bubbles, taken branch/jump flushes and multi-cycle data-memory waits with a timeout watchdog. Sits beside the main decoder; consumes its MemRead/Branch/Jump outputs as they travel down the ID/EX and EX/MEM registers.

## Interface
- WAIT_TIMEOUT, 16: max consecutive MEM_WAIT cycles before error; legal range 2..65535
- clk  input  1  core clock, all state on rising edge
- reset  input  1  asynchronous, active-high
- id_rs1, id_rs2  input  5  source register indices of instruction in ID
- ex_rd  input  5  destination index of instruction in EX
- ex_memread  input  1  EX instruction is a load
- ex_redirect  input  1  EX resolved taken branch, JAL or JALR
- mem_req  input  1  MEM instruction is a load or store
- mem_ready  input  1  data memory completes current access this cycle
- pc_write  output  1  PC register enable
- if_id_write  output  1  IF/ID enable
- if_id_flush  output  1  IF/ID load NOP
- id_ex_write  output  1  ID/EX enable
- id_ex_flush  output  1  ID/EX load NOP (bubble)
- ex_mem_write, mem_wb_write  output  1  downstream enables
- mem_err  output  1  sticky timeout error
- stall_cycles  output  32  perf counter (see Configuration)
- redirect_count  output  32  perf counter (see Configuration)

## Operation
- States: RUN, MEM_WAIT, ERR. Reset -> RUN, timer 0, counters 0.
- Priority per cycle: freeze (MEM_WAIT/ERR or new memory stall) > redirect > load-use > normal.
- Freeze: all *_write = 0, both flushes = 0. Asserted when state is ERR, or (state RUN or MEM_WAIT) and mem_req=1 and mem_ready=0.
- Redirect (not frozen, ex_redirect=1): if_id_flush=1, id_ex_flush=1, all writes=1. Load-use ignored that cycle.
- Load-use (not frozen, no redirect): ex_memread=1, ex_rd!=0, ex_rd==id_rs1 or ex_rd==id_rs2 -> pc_write=0, if_id_write=0, id_ex_flush=1, others write=1. Exactly one bubble per hazard.
- Normal: all writes=1, flushes=0.
- Transitions: RUN -> MEM_WAIT when mem_req & !mem_ready. MEM_WAIT -> RUN when mem_ready=1 (release same cycle, normal/redirect/load-use rules apply). MEM_WAIT -> ERR when timer==WAIT_TIMEOUT-1 and mem_ready=0. ERR held until reset.
- Timer: cleared on entry to MEM_WAIT, +1 per MEM_WAIT cycle, saturating. mem_err=1 iff state ERR.
- Redirect arriving during freeze is not lost: EX is frozen, so ex_redirect stays asserted and takes effect on release.
- Outputs combinational from state and inputs; no output registering.

## Timing
- Reset outputs (state RUN, inputs idle): all *_write=1, flushes=0, mem_err=0, counters 0.
- Load-use and redirect: zero latency, same-cycle controls.
- Memory stall: freeze same cycle mem_ready=0 seen; release same cycle mem_ready=1 seen.
- Timeout: with mem_ready held 0, ERR entered on edge after the WAIT_TIMEOUT-th MEM_WAIT cycle; mem_err rises that edge.
- Reset mid-MEM_WAIT or ERR: immediate return to RUN, timer and counters cleared.

## Configuration
- HAZARD_PERF_EN defined: stall_cycles +1 every cycle pc_write=0; redirect_count +1 every cycle redirect rule applies. 32-bit, wrap to 0.
- Undefined: no counter flops; both ports tied to 0. Port list unchanged.

## Structure
- hazard_pkg: state enum (RUN, MEM_WAIT, ERR), REG_ZERO = 5'd0, PERF_W = 32.
- Sub-module hazard_wait_timer: clear/enable/saturating counter with WAIT_TIMEOUT parameter, outputs expire flag.
- Top holds FSM, priority logic, optional counters.

## Test plan
- Load-use: ex_memread=1, ex_rd=5, id_rs2=5 -> one cycle pc_write=0, if_id_write=0, id_ex_flush=1; next cycle (ex_memread=0) normal. ex_rd=0 same stimulus -> no stall.
- Redirect + load-use same cycle: ex_redirect=1, load-use conditions true -> both flushes=1, pc_write=1, no bubble.
- Memory wait: mem_req=1, mem_ready=0 for 3 cycles then 1 -> 3 frozen cycles, release on 4th; stall_cycles=3 with HAZARD_PERF_EN.
- Redirect during freeze: ex_redirect=1 held across 2-cycle wait -> no flush while frozen, flushes on release cycle, redirect_count=1.
- Timeout: WAIT_TIMEOUT=4, mem_ready=0 held -> mem_err=1 after 4th wait cycle, all writes 0 thereafter; mem_ready=1 does not recover; reset clears.
- Reset async mid-MEM_WAIT -> outputs to reset values without a clock edge.
